pipelined_rc_adder: RTL and testbench
=====================================

// Module: pipelined_rc_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor. Successor to the 4-bit combinational adder.
//   Splits a WIDTH-bit add into STAGES ripple chunks with registered carries between chunks.
//   Valid/ready handshakes on both sides. Sits between operand producers and datapath consumers
//   that need a wide add at full clock rate.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must satisfy WIDTH % STAGES == 0
//   STAGES  4   pipeline stages; each ripples CHUNK = WIDTH/STAGES bits; STAGES >= 1
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      adder accepts beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0; ignored when sub=1
//   sub        in   1      1: compute a - b (b inverted, carry into bit 0 forced to 1)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   carry_out  out  1      carry out of MSB; for sub, 1 means no borrow (a >= b unsigned)
//   overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (rst_n low, async): all stage valid bits, out_valid, sum, carry_out and overflow clear to 0.
//     Any beats in flight are discarded. Deassertion takes effect synchronously to clk.
//   - Transfers: input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
//   - Global stall:
//       advance  = !out_valid | out_ready
//       in_ready = advance (combinational; no dependence on in_valid)
//     When advance=0, every stage register holds its value, including data and valid.
//   - Stage k (k = 0..STAGES-1):
//       chunk k = bits [k*CHUNK +: CHUNK], added with the carry registered from stage k-1.
//       Stage 0 uses the effective carry_in: sub ? 1 : carry_in.
//       Completed low chunks and the not-yet-used high operand chunks ride along in skew registers.
//   - Latency: exactly STAGES cycles from input transfer to out_valid, absent stalls.
//     Throughput is 1 beat/cycle. Bubbles (in_valid=0) propagate as invalid stages.
//   - Output ordering: strictly in order; one result per accepted input; no drop or duplication.
//   - Output registers: sum/carry_out/overflow are registered and change only when advance=1.
//     Values are held while out_valid & !out_ready. Data is don't-care when out_valid=0,
//     but must not be X after reset.
//   - Arithmetic: {carry_out, sum} = a + (sub ? ~b : b) + (sub ? 1 : carry_in), modulo 2^(WIDTH+1).
//     overflow follows the same operand inversion.
//   - Boundaries:
//       all-ones + 1 wraps sum to 0 with carry_out=1.
//       0 - 1 gives all-ones with carry_out=0.
//       Simultaneous input and output transfer in the same cycle is legal and loses nothing.
//       STAGES=1 degenerates to a single registered add with 1-cycle latency.
//       STAGES=WIDTH gives 1-bit chunks.
//   - Parameter check: an illegal WIDTH/STAGES combination triggers $error at elaboration.
// TESTING  (WIDTH=16, STAGES=4 unless noted)
//   1. Basic add: a=16'h1234, b=16'h4321, cin=0, sub=0, out_ready=1
//      -> 4 cycles later: sum=16'h5555, carry_out=0, overflow=0.
//   2. Carry across all chunks: a=16'hFFFF, b=16'h0000, cin=1
//      -> sum=16'h0000, carry_out=1, overflow=0.
//      Also a=16'h7FFF, b=1 -> sum=16'h8000, overflow=1.
//   3. Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored)
//      -> sum=16'hFFFE, carry_out=0.
//      Also a=7, b=5 -> sum=16'h0002, carry_out=1.
//   4. Streaming and backpressure: 20 back-to-back random beats, out_ready toggled pseudo-randomly
//      -> all 20 results match the reference model, in order.
//      in_ready=0 exactly when out_valid & !out_ready. Output is stable while stalled.
//   5. Reset mid-operation: assert rst_n=0 with 3 beats in flight
//      -> out_valid=0 and outputs 0 immediately (async).
//      After release, no stale beat emerges; the next input yields a correct result in 4 cycles.
//   6. Parameter sweep: WIDTH=8/STAGES=1, WIDTH=32/STAGES=8, WIDTH=4/STAGES=4, random traffic
//      -> latency equals STAGES; results match the reference model.

Source files
------------

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add is split into STAGES chunks of CHUNK bits; each stage ripples
// one chunk using the carry registered by the previous stage. Operands not yet
// consumed and result chunks already produced travel along in skew registers.
// The last stage register is the output register. One global stall signal
// freezes every stage while the consumer back-pressures.
module pipelined_rc_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Guarded so an illegal STAGES still elaborates far enough to report the error.
  localparam int NST   = (STAGES > 0) ? STAGES : 1;
  localparam int CHUNK = (WIDTH >= NST) ? (WIDTH / NST) : 1;
  localparam int LAST  = NST - 1;

  if (STAGES < 1 || WIDTH < 1 || (WIDTH % NST) != 0) begin : g_param_err
    $error("pipelined_rc_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // Stage registers (index k = register written by stage k)
  logic [WIDTH-1:0] a_q [NST];
  logic [WIDTH-1:0] b_q [NST];
  logic [WIDTH-1:0] s_q [NST];
  logic             c_q [NST];
  logic             v_q [NST];
  logic             ovf_q;

  // Stage inputs: operands/carry feeding stage k, either from the ports or stage k-1
  logic [WIDTH-1:0] src_a [NST];
  logic [WIDTH-1:0] src_b [NST];
  logic [WIDTH-1:0] src_s [NST];
  logic             src_c [NST];
  logic             src_v [NST];

  // Next-state values
  logic [WIDTH-1:0] s_d   [NST];
  logic [CHUNK:0]   part_d [NST];
  logic             cmsb_d;
  logic             ovf_d;
  logic             advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NST; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1, so the operand is inverted once on entry.
      assign src_a[k] = a;
      assign src_b[k] = sub ? ~b : b;
      assign src_s[k] = '0;
      assign src_c[k] = sub | carry_in;
      assign src_v[k] = in_valid;
    end else begin : g_rest
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_v[k] = v_q[k-1];
    end

    assign part_d[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                     + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, src_c[k]};
  end

  // Merge each stage's freshly computed chunk into the partial result it carries
  always_comb begin
    for (int unsigned k = 0; k < NST; k++) begin
      s_d[k] = src_s[k];
      s_d[k][k*CHUNK +: CHUNK] = part_d[k][CHUNK-1:0];
    end
  end

  // Signed overflow from the MSB chunk: carry into MSB recovered from a^b^sum at that bit
  always_comb begin
    cmsb_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
    ovf_d  = cmsb_d ^ part_d[LAST][CHUNK];
  end

  // Pipeline registers: cleared on reset, all held together while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NST; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < NST; k++) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= s_d[k];
        c_q[k] <= part_d[k][CHUNK];
        v_q[k] <= src_v[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry_out = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Bench for pipelined_rc_adder: directed arithmetic corners, randomized streaming
// with back-pressure, mid-flight reset, and a parameter sweep on extra instances.
// Expected results come from a plain arithmetic model plus an in-order queue.
module tb_pipelined_rc_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, carry_in, sub;
  logic         out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] a, b, sum;
  logic         go = 1'b0;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  pipelined_rc_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  // Reference: {overflow, carry_out, sum} of a w-bit add/subtract, by plain arithmetic
  function automatic logic [63:0] ref_add(int w, logic [63:0] x, logic [63:0] y,
                                          logic ci, logic sb);
    logic [63:0] mask, xm, yz, tot, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    xm   = x & mask;
    yz   = sb ? (~y & mask) : (y & mask);
    tot  = xm + yz + {63'd0, sb | ci};
    s    = tot & mask;
    co   = tot[w];
    ov   = (xm[w-1] == yz[w-1]) && (s[w-1] != xm[w-1]);
    return ({62'd0, ov, co} << w) | s;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] exp;
    int          t;
  } beat_t;

  beat_t          q[$];
  logic           prev_stall = 1'b0;
  logic [W+2:0]   snap;
  bit             chk_lat = 1'b1;

  // One clock cycle: drive at negedge, then judge handshakes and outputs
  task automatic step(input logic iv, input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic ci, input logic si, input logic ro, output logic acc);
    beat_t bt;
    @(negedge clk);
    cyc++;
    in_valid = iv; a = ai; b = bi; carry_in = ci; sub = si; out_ready = ro;
    #1;
    check_eq("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stall) check_eq("hold", {overflow, carry_out, sum, out_valid}, snap);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check_eq("spurious_out_valid", out_valid, 0);
      else begin
        bt = q.pop_front();
        check_eq("result", {overflow, carry_out, sum}, bt.exp);
        if (chk_lat) check_eq("latency", cyc - bt.t, S);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      bt.exp = ref_add(W, ai, bi, ci, si);
      bt.t   = cyc;
      q.push_back(bt);
    end
    prev_stall = out_valid && !out_ready;
    snap       = {overflow, carry_out, sum, out_valid};
  endtask

  task automatic flush();
    logic acc;
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check_eq("drained", q.size(), 0);
  endtask

  // Parameter sweep: free-running consumer, so latency must be exactly SS cycles
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
    localparam int SS = (g == 0) ? 1 : ((g == 1) ? 8 : 4);
    logic          iv, ir, vo, co, of, ci, sb;
    logic [SW-1:0] xa, xb, s;
    bit            hv[64];
    logic [63:0]   he[64];
    bit            done = 1'b0;

    pipelined_rc_adder #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(xa), .b(xb), .carry_in(ci), .sub(sb),
      .out_valid(vo), .out_ready(1'b1),
      .sum(s), .carry_out(co), .overflow(of)
    );

    initial begin
      iv = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
      wait (go);
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        check_eq($sformatf("sw%0d_in_ready", g), ir, 1);
        if (c >= SS && hv[c-SS]) begin
          check_eq($sformatf("sw%0d_valid", g), vo, 1);
          check_eq($sformatf("sw%0d_result", g), {of, co, s}, he[c-SS]);
        end else begin
          check_eq($sformatf("sw%0d_idle", g), vo, 0);
        end
        hv[c] = ($urandom_range(0, 3) != 0);
        xa    = SW'($urandom);
        xb    = SW'($urandom);
        ci    = 1'($urandom_range(0, 1));
        sb    = 1'($urandom_range(0, 1));
        iv    = hv[c];
        he[c] = ref_add(SW, 64'(xa), 64'(xb), ci, sb);
      end
      @(negedge clk);
      iv   = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    logic         acc, have, rc, rs;
    logic [W-1:0] ra, rb;
    int           sent;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    ra = '0; rb = '0; rc = 1'b0; rs = 1'b0; have = 1'b0; sent = 0;

    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_outputs", {overflow, carry_out, sum}, 0);
    check_eq("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed corners, back-to-back, consumer always ready
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, acc);
    step(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, acc);
    step(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
    flush();

    // Streaming with pseudo-random back-pressure; beats held until accepted
    chk_lat = 1'b0;
    for (int i = 0; i < 400 && sent < 20; i++) begin
      if (!have) begin
        ra = W'($urandom); rb = W'($urandom);
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      step(1'b1, ra, rb, rc, rs, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        sent++;
        have = 1'b0;
      end
    end
    check_eq("stream_sent", sent, 20);
    flush();
    chk_lat = 1'b1;

    // Reset with one result waiting at the output and three beats in flight
    for (int i = 0; i < 4; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check_eq("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_valid", out_valid, 0);
    check_eq("async_reset_outputs", {overflow, carry_out, sum}, 0);
    q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1, acc);
    flush();

    // Parameter sweep on the extra instances
    in_valid = 1'b0;
    go = 1'b1;
    repeat (75) @(negedge clk);
    check_eq("sweep0_done", g_sw[0].done, 1);
    check_eq("sweep1_done", g_sw[1].done, 1);
    check_eq("sweep2_done", g_sw[2].done, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
